uart_mem_loader: RTL
====================

UART_MEM_LOADER -- requirements
Module: uart_mem_loader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 434; core clocks per UART bit (50 MHz / 115200).
REQ-002 SHALL have parameter ADDR_W, default 16; word-address width, matching dmem/imem a[17:2].
REQ-003 SHALL have parameter TIMEOUT_BITS, default 2048; maximum idle bit-times between bytes during a load.
REQ-004 SHALL have port clk, input, 1; single core clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1; asynchronous, active-low reset.
REQ-006 SHALL have port rxd, input, 1; asynchronous UART line, 8N1, LSB first, idle high.
REQ-007 SHALL have port mem_we, output, 1; one-cycle memory write strobe.
REQ-008 SHALL have port mem_addr, output, ADDR_W; word address of the current write.
REQ-009 SHALL have port mem_wdata, output, 32; write data, valid while mem_we=1.
REQ-010 SHALL have port busy, output, 1; load in progress; the top level uses it to hold the core in reset.
REQ-011 SHALL have port done, output, 1; last load completed successfully (sticky).
REQ-012 SHALL have port err, output, 1; last load aborted (sticky).

Function
REQ-013 SHALL pass rxd through a 2-flop synchronizer; all rxd references below mean the synchronized value.
REQ-014 SHALL detect a start bit on a high-to-low transition while the receiver is idle, and re-sample at CLK_DIV/2 clocks; if rxd=1 there, SHALL drop it as a glitch and return to receiver idle.
REQ-015 SHALL sample data bits at CLK_DIV-clock intervals from the mid-start point, shifting LSB first, then sample the stop bit one interval later.
REQ-016 SHALL flag a frame error on stop bit = 0; a byte is valid only with stop bit = 1.
REQ-017 SHALL implement the protocol FSM: S_SYNC, S_LEN0, S_LEN1, S_DATA, S_DONE.
REQ-018 S_SYNC SHALL ignore every byte except 0xA5; on 0xA5 it SHALL clear done and err, set busy, zero mem_addr and go to S_LEN0.
REQ-019 S_LEN0 SHALL latch the count low byte; S_LEN1 SHALL latch the high byte (16-bit word count N, little-endian).
REQ-020 If N=0, S_LEN1 SHALL go directly to S_DONE with no write.
REQ-021 S_DATA SHALL assemble 4 bytes little-endian (first byte = bits 7:0) into mem_wdata.
REQ-022 SHALL pulse mem_we for exactly one clock, the clock after the 4th byte's stop bit is sampled, with mem_addr equal to the word index.
REQ-023 SHALL increment mem_addr on the clock after each mem_we, wrapping modulo 2^ADDR_W.
REQ-024 After the Nth write, SHALL enter S_DONE: busy=0, done=1 for one clock, then return to S_SYNC; done SHALL stay high until the next 0xA5.
REQ-025 While busy=1, SHALL treat the value 0xA5 as ordinary data (no resynchronization).
REQ-026 While busy=1, a frame error or more than TIMEOUT_BITS bit-times with no start bit SHALL abort: err=1, busy=0, return to S_SYNC, no further mem_we.
REQ-027 A frame error in S_SYNC SHALL be ignored, and err SHALL be left unchanged.
REQ-028 SHALL keep mem_we=0 outside S_DATA write cycles.

Reset
REQ-029 SHALL reset asynchronously on rst_n=0: FSM=S_SYNC, receiver idle, synchronizer=1, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0.
REQ-030 Reset mid-load SHALL discard any partial byte or word without producing a mem_we; after release the block SHALL wait for a fresh 0xA5.

Verification (CLK_DIV=8, TIMEOUT_BITS=32)
REQ-031 Send A5 02 00 78 56 34 12 EF BE AD DE -> two writes: (addr 0, 0x12345678) and (addr 1, 0xDEADBEEF); busy falls after the 2nd write; done=1; err=0.
REQ-032 Send 00 A5 00 00 -> the leading 00 is ignored; no mem_we; done=1 after the count.
REQ-033 Send A5 01 00 11 22 then a byte with stop bit = 0 -> err=1, busy=0, no mem_we.
REQ-034 Send A5 01 00 11, then hold rxd high for 40 bit-times -> err=1 after 32 bit-times, busy=0.
REQ-035 Send a 2-clock low glitch on rxd while idle -> no byte received; FSM stays in S_SYNC.
REQ-036 Assert rst_n=0 during the 3rd data byte, then send a full valid load -> no write before the reset; the new load writes from addr 0.

Source files
------------

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: 8N1 UART receiver feeding a framed loader (A5, 16-bit word count, LE words)
// that streams 32-bit words into memory while holding busy high.
module uart_mem_loader #(
    parameter int CLK_DIV      = 434,
    parameter int ADDR_W       = 16,
    parameter int TIMEOUT_BITS = 2048
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rxd,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam int TW = $clog2(TIMEOUT_BITS + 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {S_SYNC, S_LEN0, S_LEN1, S_DATA, S_DONE} state_t;

    logic [1:0]        r_sync;
    logic              r_rx_prev;
    rx_state_t         r_rx_state;
    logic [CW-1:0]     r_rx_cnt;
    logic [2:0]        r_rx_bit;
    logic [7:0]        r_rx_shift;
    logic              r_rx_valid;
    logic              r_rx_ferr;
    logic [CW-1:0]     r_to_cnt;
    logic [TW-1:0]     r_to_bits;
    state_t            r_state;
    logic [15:0]       r_len;
    logic [15:0]       r_wcnt;
    logic [1:0]        r_bidx;
    logic [31:0]       r_wdata;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic w_rx;
    logic w_tick;
    logic w_timeout;
    logic w_abort;

    assign w_rx      = r_sync[1];
    assign w_tick    = r_rx_cnt == DIV_LAST;
    assign w_timeout = r_to_bits == TW'(TIMEOUT_BITS);
    assign w_abort   = r_busy && (r_rx_ferr || w_timeout);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync     <= 2'b11;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], rxd};
            r_rx_prev  <= w_rx;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (r_rx_prev && !w_rx) begin
                        r_rx_state <= RX_START;
                        r_rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == HALF_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= w_rx ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (w_tick) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {w_rx, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 1'b1;
                        if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (w_tick) begin
                        r_rx_cnt   <= '0;
                        r_rx_valid <= w_rx;
                        r_rx_ferr  <= !w_rx;
                        r_rx_state <= RX_IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // Idle bit-time counter; only runs while a load is active and the line is quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt  <= '0;
            r_to_bits <= '0;
        end else if (!r_busy || r_rx_state != RX_IDLE) begin
            r_to_cnt  <= '0;
            r_to_bits <= '0;
        end else if (r_to_cnt == DIV_LAST) begin
            r_to_cnt <= '0;
            if (!w_timeout) r_to_bits <= r_to_bits + 1'b1;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_SYNC;
            r_len   <= '0;
            r_wcnt  <= '0;
            r_bidx  <= '0;
            r_wdata <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (r_we) r_addr <= r_addr + 1'b1;
            if (w_abort) begin
                r_err   <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_SYNC;
            end else begin
                case (r_state)
                    S_SYNC: begin
                        if (r_rx_valid && r_rx_shift == 8'hA5) begin
                            r_done  <= 1'b0;
                            r_err   <= 1'b0;
                            r_busy  <= 1'b1;
                            r_addr  <= '0;
                            r_state <= S_LEN0;
                        end
                    end
                    S_LEN0: begin
                        if (r_rx_valid) begin
                            r_len[7:0] <= r_rx_shift;
                            r_state    <= S_LEN1;
                        end
                    end
                    S_LEN1: begin
                        if (r_rx_valid) begin
                            r_len[15:8] <= r_rx_shift;
                            r_wcnt      <= '0;
                            r_bidx      <= '0;
                            r_state     <= ({r_rx_shift, r_len[7:0]} == 16'd0) ? S_DONE : S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (r_rx_valid) begin
                            r_wdata <= {r_rx_shift, r_wdata[31:8]};
                            r_bidx  <= r_bidx + 1'b1;
                            if (r_bidx == 2'd3) begin
                                r_we   <= 1'b1;
                                r_wcnt <= r_wcnt + 1'b1;
                                if (r_wcnt + 16'd1 == r_len) r_state <= S_DONE;
                            end
                        end
                    end
                    S_DONE: begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_SYNC;
                    end
                    default: r_state <= S_SYNC;
                endcase
            end
        end
    end

    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
endmodule
